// File: rtl/core_control_if.sv
// ============================================================================
//  core_control_if : instruction/data memory handshake bundle for core_control
//  Rev 1.0
// ============================================================================
`default_nettype none

interface core_control_if;
  logic imem_req;
  logic imem_ack;
  logic ir_load;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req,
    output ir_load,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  ir_load,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output dmem_ack
  );
endinterface

`default_nettype wire

// File: rtl/core_control.sv
// ============================================================================
//  core_control : multi-cycle instruction sequencer with fetch/mem timeouts
//  Rev 1.0
// ============================================================================
`default_nettype none

module core_control (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          run,
  core_control_if.master     bus,
  input  wire logic          is_load,
  input  wire logic          is_store,
  input  wire logic          is_branch,
  input  wire logic          is_jump,
  input  wire logic          illegal,
  input  wire logic          br_taken,
  output logic               alu_en,
  output logic               reg_we,
  output logic               pc_we,
  output logic [1:0]         pc_sel,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic               halted,
  output logic [31:0]        instret,
  output logic [2:0]         state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [1:0] C_CAUSE_ILLEGAL = 2'd0;
  localparam logic [1:0] C_CAUSE_IMEM    = 2'd1;
  localparam logic [1:0] C_CAUSE_DMEM    = 2'd2;

  logic [2:0]  state_q,   state_d;
  logic [7:0]  wait_q,    wait_d;
  logic        ld_q,      ld_d;
  logic        st_q,      st_d;
  logic        br_q,      br_d;
  logic        jmp_q,     jmp_d;
  logic        tk_q,      tk_d;
  logic [1:0]  cause_q,   cause_d;
  logic        halted_q,  halted_d;
  logic [31:0] instret_q, instret_d;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    ld_d      = ld_q;
    st_d      = st_q;
    br_d      = br_q;
    jmp_d     = jmp_q;
    tk_d      = tk_q;
    cause_d   = cause_q;
    halted_d  = halted_q;
    instret_d = instret_q;
    case (state_q)
      S_IDLE: begin
        if (run && !halted_q) begin
          state_d = S_FETCH;
          wait_d  = 8'd0;
        end
      end
      S_FETCH: begin
        // An ack in the final wait cycle beats the timeout.
        if (bus.imem_ack) begin
          state_d = S_DECODE;
        end else if (wait_q == 8'hFF) begin
          state_d  = S_TRAP;
          cause_d  = C_CAUSE_IMEM;
          halted_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        ld_d  = is_load;
        st_d  = is_store;
        br_d  = is_branch;
        jmp_d = is_jump;
        tk_d  = br_taken;
        if (illegal) begin
          state_d  = S_TRAP;
          cause_d  = C_CAUSE_ILLEGAL;
          halted_d = 1'b1;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
          wait_d  = 8'd0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          state_d = S_WB;
        end else if (wait_q == 8'hFF) begin
          state_d  = S_TRAP;
          cause_d  = C_CAUSE_DMEM;
          halted_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        instret_d = instret_q + 32'd1;
        if (run) begin
          state_d = S_FETCH;
          wait_d  = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TRAP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wait_q    <= 8'd0;
      ld_q      <= 1'b0;
      st_q      <= 1'b0;
      br_q      <= 1'b0;
      jmp_q     <= 1'b0;
      tk_q      <= 1'b0;
      cause_q   <= 2'd0;
      halted_q  <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      ld_q      <= ld_d;
      st_q      <= st_d;
      br_q      <= br_d;
      jmp_q     <= jmp_d;
      tk_q      <= tk_d;
      cause_q   <= cause_d;
      halted_q  <= halted_d;
      instret_q <= instret_d;
    end
  end

  // Strobes decode from the registered state; only ir_load follows the ack directly.
  always_comb begin
    bus.imem_req = (state_q == S_FETCH);
    bus.ir_load  = (state_q == S_FETCH) && bus.imem_ack;
    bus.dmem_req = (state_q == S_MEM);
    bus.dmem_we  = (state_q == S_MEM) && st_q;
    alu_en       = (state_q == S_EXEC);
    reg_we       = (state_q == S_WB) && (ld_q || !(st_q || br_q));
    pc_we        = (state_q == S_WB) || (state_q == S_TRAP);
    trap         = (state_q == S_TRAP);
    if (state_q == S_TRAP) begin
      pc_sel = 2'd2;
    end else if ((state_q == S_WB) && (jmp_q || (br_q && tk_q))) begin
      pc_sel = 2'd1;
    end else begin
      pc_sel = 2'd0;
    end
  end

  assign trap_cause = cause_q;
  assign halted     = halted_q;
  assign instret    = instret_q;
  assign state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_core_control.sv
// ============================================================================
//  tb_core_control : directed self-checking bench for core_control
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_core_control;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        is_load = 1'b0, is_store = 1'b0, is_branch = 1'b0;
  logic        is_jump = 1'b0, illegal = 1'b0, br_taken = 1'b0;
  logic        alu_en, reg_we, pc_we, trap, halted;
  logic [1:0]  pc_sel, trap_cause;
  logic [31:0] instret;
  logic [2:0]  state;
  int          vectors = 0;
  int          errors  = 0;

  core_control_if bus ();

  core_control dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .bus        (bus),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_branch  (is_branch),
    .is_jump    (is_jump),
    .illegal    (illegal),
    .br_taken   (br_taken),
    .alu_en     (alu_en),
    .reg_we     (reg_we),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .trap       (trap),
    .trap_cause (trap_cause),
    .halted     (halted),
    .instret    (instret),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    {is_load, is_store, is_branch, is_jump, illegal, br_taken} = 6'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Steps the machine from a negedge until STATE == target, answering fetch on
  // its imem_lat-th cycle and memory on its dmem_lat-th cycle (0 = never).
  task automatic drive_until(input logic [2:0] target, input int imem_lat, input int dmem_lat,
                             output int fcyc, output int mcyc, output int wcyc,
                             output int traps, output bit ok);
    int fc = 0, mc = 0;
    fcyc = 0; mcyc = 0; wcyc = 0; traps = 0; ok = 1'b0;
    for (int n = 0; n < 700; n++) begin
      if (state === target) begin
        ok = 1'b1;
        break;
      end
      bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
      if (trap === 1'b1) traps++;
      if (bus.imem_req === 1'b1) begin
        fc++; fcyc = fc;
        if (fc == imem_lat) bus.imem_ack = 1'b1;
      end
      if (bus.dmem_req === 1'b1) begin
        mc++; mcyc = mc;
        if (bus.dmem_we === 1'b1) wcyc++;
        if (mc == dmem_lat) bus.dmem_ack = 1'b1;
      end
      tick();
    end
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({state, bus.imem_req, bus.ir_load, bus.dmem_req, bus.dmem_we, alu_en, reg_we,
         pc_we, pc_sel, trap, trap_cause, halted} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: state=%0d imem_req=%b dmem_req=%b pc_sel=%0d halted=%b, required all 0",
               state, bus.imem_req, bus.dmem_req, pc_sel, halted);
    end
    vectors++;
    if (instret !== 32'd0) begin
      errors++; $display("FAIL reset_instret: got %h required 0", instret);
    end
  endtask

  task automatic test_alu_op();
    logic [2:0] exp_states [8] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (state !== exp_states[i]) begin
        errors++; $display("FAIL alu_state[%0d]: got %0d required %0d", i, state, exp_states[i]);
      end
      if (i == 3) begin
        bus.imem_ack = 1'b1; #1;
        vectors++;
        if (bus.ir_load !== 1'b1) begin
          errors++; $display("FAIL alu_ir_load: got %b required 1", bus.ir_load);
        end
      end
      if (i == 5) begin
        vectors++;
        if (alu_en !== 1'b1) begin
          errors++; $display("FAIL alu_en: got %b required 1", alu_en);
        end
      end
      if (i == 6) begin
        vectors++;
        if ({pc_we, reg_we, pc_sel} !== 4'b1100) begin
          errors++; $display("FAIL alu_wb: pc_we=%b reg_we=%b pc_sel=%0d required 1,1,0", pc_we, reg_we, pc_sel);
        end
      end
      tick();
      bus.imem_ack = 1'b0;
    end
    vectors++;
    if (instret !== 32'd1) begin
      errors++; $display("FAIL alu_instret: got %0d required 1", instret);
    end
  endtask

  task automatic test_store();
    int f, m, w, t; bit ok;
    do_reset();
    is_store = 1'b1; run = 1'b1;
    drive_until(3'd5, 1, 4, f, m, w, t, ok);
    vectors++;
    if (!ok || m != 4 || w != 4) begin
      errors++; $display("FAIL store_mem: reached=%b req_cycles=%0d we_cycles=%0d required 1,4,4", ok, m, w);
    end
    vectors++;
    if ({pc_we, reg_we, pc_sel} !== 4'b1000) begin
      errors++; $display("FAIL store_wb: pc_we=%b reg_we=%b pc_sel=%0d required 1,0,0", pc_we, reg_we, pc_sel);
    end
    run = 1'b0;
    tick();
    vectors++;
    if (state !== 3'd0 || instret !== 32'd1) begin
      errors++; $display("FAIL store_to_idle: state=%0d instret=%0d required 0,1", state, instret);
    end
  endtask

  task automatic test_load_jump();
    int f, m, w, t; bit ok;
    do_reset();
    is_load = 1'b1; run = 1'b1;
    drive_until(3'd5, 2, 1, f, m, w, t, ok);
    vectors++;
    if (!ok || m != 1 || w != 0 || reg_we !== 1'b1 || pc_sel !== 2'd0) begin
      errors++; $display("FAIL load_wb: reached=%b mem=%0d we=%0d reg_we=%b pc_sel=%0d required 1,1,0,1,0",
                         ok, m, w, reg_we, pc_sel);
    end
    tick();
    is_load = 1'b0; is_jump = 1'b1;
    drive_until(3'd5, 1, 0, f, m, w, t, ok);
    vectors++;
    if (!ok || m != 0 || reg_we !== 1'b1 || pc_sel !== 2'd1) begin
      errors++; $display("FAIL jump_wb: reached=%b mem=%0d reg_we=%b pc_sel=%0d required 1,0,1,1", ok, m, reg_we, pc_sel);
    end
  endtask

  task automatic test_branch();
    int f, m, w, t; bit ok;
    do_reset();
    is_branch = 1'b1; br_taken = 1'b1; run = 1'b1;
    drive_until(3'd5, 1, 0, f, m, w, t, ok);
    vectors++;
    if (!ok || reg_we !== 1'b0 || pc_sel !== 2'd1) begin
      errors++; $display("FAIL branch_taken: reached=%b reg_we=%b pc_sel=%0d required 1,0,1", ok, reg_we, pc_sel);
    end
    tick();
    br_taken = 1'b0;
    drive_until(3'd5, 1, 0, f, m, w, t, ok);
    vectors++;
    if (!ok || reg_we !== 1'b0 || pc_sel !== 2'd0 || pc_we !== 1'b1) begin
      errors++; $display("FAIL branch_not_taken: reached=%b reg_we=%b pc_sel=%0d pc_we=%b required 1,0,0,1",
                         ok, reg_we, pc_sel, pc_we);
    end
  endtask

  task automatic test_illegal();
    int f, m, w, t; bit ok;
    do_reset();
    illegal = 1'b1; is_load = 1'b1; run = 1'b1;
    drive_until(3'd6, 1, 1, f, m, w, t, ok);
    vectors++;
    if (!ok || m != 0 || {trap, pc_we, pc_sel, trap_cause, halted} !== 7'b1110001) begin
      errors++; $display("FAIL illegal_trap: reached=%b mem=%0d trap=%b pc_we=%b pc_sel=%0d cause=%0d halted=%b required 1,0,1,1,2,0,1",
                         ok, m, trap, pc_we, pc_sel, trap_cause, halted);
    end
    illegal = 1'b0; is_load = 1'b0;
    tick();
    vectors++;
    if (state !== 3'd0 || trap !== 1'b0 || halted !== 1'b1) begin
      errors++; $display("FAIL illegal_after: state=%0d trap=%b halted=%b required 0,0,1", state, trap, halted);
    end
    for (int i = 0; i < 5; i++) tick();
    vectors++;
    if (state !== 3'd0 || bus.imem_req !== 1'b0 || instret !== 32'd0) begin
      errors++; $display("FAIL halted_stays_idle: state=%0d imem_req=%b instret=%0d required 0,0,0", state, bus.imem_req, instret);
    end
  endtask

  task automatic test_timeout();
    int f, m, w, t; bit ok;
    do_reset();
    run = 1'b1;
    drive_until(3'd6, 0, 0, f, m, w, t, ok);
    vectors++;
    if (!ok || f != 256 || trap_cause !== 2'd1 || trap !== 1'b1) begin
      errors++; $display("FAIL imem_timeout: reached=%b req_cycles=%0d cause=%0d trap=%b required 1,256,1,1", ok, f, trap_cause, trap);
    end
    tick();
    vectors++;
    if (state !== 3'd0 || trap_cause !== 2'd1 || halted !== 1'b1) begin
      errors++; $display("FAIL cause_hold: state=%0d cause=%0d halted=%b required 0,1,1", state, trap_cause, halted);
    end
    do_reset();
    run = 1'b1;
    drive_until(3'd2, 256, 0, f, m, w, t, ok);
    vectors++;
    if (!ok || f != 256 || t != 0 || halted !== 1'b0) begin
      errors++; $display("FAIL imem_late_ack: reached=%b req_cycles=%0d traps=%0d halted=%b required 1,256,0,0", ok, f, t, halted);
    end
    do_reset();
    is_store = 1'b1; run = 1'b1;
    drive_until(3'd6, 1, 0, f, m, w, t, ok);
    vectors++;
    if (!ok || m != 256 || trap_cause !== 2'd2) begin
      errors++; $display("FAIL dmem_timeout: reached=%b req_cycles=%0d cause=%0d required 1,256,2", ok, m, trap_cause);
    end
  endtask

  task automatic test_reset_mid_mem();
    int f, m, w, t; bit ok;
    do_reset();
    is_load = 1'b1; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_until(3'd5, 1, 1, f, m, w, t, ok);
      tick();
    end
    drive_until(3'd4, 1, 0, f, m, w, t, ok);
    vectors++;
    if (!ok || bus.dmem_req !== 1'b1 || instret !== 32'd5) begin
      errors++; $display("FAIL pre_reset_mem: reached=%b dmem_req=%b instret=%0d required 1,1,5", ok, bus.dmem_req, instret);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (state !== 3'd0 || bus.dmem_req !== 1'b0 || instret !== 32'd0) begin
      errors++; $display("FAIL reset_mid_mem: state=%0d dmem_req=%b instret=%0d required 0,0,0", state, bus.dmem_req, instret);
    end
    rst = 1'b0; run = 1'b0; bus.dmem_ack = 1'b1;
    tick(); tick();
    bus.dmem_ack = 1'b0;
    vectors++;
    if (state !== 3'd0 || bus.dmem_req !== 1'b0 || instret !== 32'd0) begin
      errors++; $display("FAIL late_ack_idle: state=%0d dmem_req=%b instret=%0d required 0,0,0", state, bus.dmem_req, instret);
    end
  endtask

  task automatic test_instret_wrap();
    int f, m, w, t; bit ok;
    do_reset();
    force dut.instret_q = 32'hFFFF_FFFE;
    #1;
    release dut.instret_q;
    run = 1'b1;
    drive_until(3'd5, 1, 0, f, m, w, t, ok);
    tick();
    vectors++;
    if (!ok || instret !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL instret_max: reached=%b got %h required ffffffff", ok, instret);
    end
    drive_until(3'd5, 1, 0, f, m, w, t, ok);
    tick();
    vectors++;
    if (!ok || instret !== 32'd0) begin
      errors++; $display("FAIL instret_wrap: reached=%b got %h required 00000000", ok, instret);
    end
  endtask

  initial begin
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    tick();
    test_reset();
    test_alu_op();
    test_store();
    test_load_jump();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    test_instret_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/core_control.md
CORE_CONTROL -- requirements
Module: core_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLK  in  1  rising-edge clock; RST  in  1  synchronous active-high reset.
REQ-002 The block SHALL provide these control inputs: RUN  in  1  level enable for instruction sequencing.
REQ-003 The block SHALL provide this instruction-fetch interface: IMEM_REQ  out  1  fetch request; IMEM_ACK  in  1  fetch data valid; IR_LOAD  out  1  capture fetched word into instruction register.
REQ-004 The block SHALL take these registered decoder flags as inputs: IS_LOAD, IS_STORE, IS_BRANCH, IS_JUMP, ILLEGAL  in  1 each  decoded instruction class.
REQ-005 The block SHALL take this branch result as an input: BR_TAKEN  in  1  branch comparison result.
REQ-006 The block SHALL provide this data-memory interface: DMEM_REQ  out  1  data access request; DMEM_WE  out  1  write strobe; DMEM_ACK  in  1  access complete.
REQ-007 The block SHALL provide these datapath controls: ALU_EN  out  1  execute; REG_WE  out  1  register-file write; PC_WE  out  1  PC update; PC_SEL  out  2  0=PC+4, 1=target, 2=trap vector.
REQ-008 The block SHALL provide these status outputs: TRAP  out  1  one-cycle trap pulse; TRAP_CAUSE  out  2  0=illegal, 1=imem timeout, 2=dmem timeout; HALTED  out  1  sticky halt; INSTRET  out  32  retired-instruction count; STATE  out  3  current state.

Function
REQ-009 The FSM SHALL use these state encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; code 7 SHALL go to IDLE.
REQ-010 In IDLE, the FSM SHALL go to FETCH when RUN=1 and HALTED=0; otherwise it SHALL remain in IDLE.
REQ-011 In FETCH, the block SHALL hold IMEM_REQ=1; on IMEM_ACK=1 it SHALL pulse IR_LOAD in that same cycle and go to DECODE.
REQ-012 DECODE SHALL last exactly one cycle, covering the decoder's register stage, then go to EXEC.
REQ-013 In EXEC, the block SHALL assert ALU_EN=1 and latch IS_LOAD, IS_STORE, IS_BRANCH, IS_JUMP and BR_TAKEN internally; MEM and WB SHALL use only these latched copies.
REQ-014 Transitions out of EXEC SHALL follow this priority: ILLEGAL -> TRAP (cause 0); otherwise IS_LOAD|IS_STORE -> MEM; otherwise -> WB.
REQ-015 In MEM, the block SHALL hold DMEM_REQ=1 with DMEM_WE equal to the latched IS_STORE; on DMEM_ACK=1 it SHALL go to WB.
REQ-016 WB SHALL last one cycle with these outputs:
- PC_WE=1.
- PC_SEL=1 if IS_JUMP, or if IS_BRANCH and BR_TAKEN; otherwise PC_SEL=0.
- REG_WE=1 unless IS_STORE or IS_BRANCH.
- INSTRET incremented by 1.
REQ-017 After WB, the FSM SHALL go to FETCH if RUN=1, else to IDLE; deasserting RUN mid-instruction SHALL NOT abort that instruction.
REQ-018 TRAP SHALL last one cycle with TRAP=1, PC_WE=1 and PC_SEL=2; HALTED SHALL set to 1 and the FSM SHALL go to IDLE.
REQ-019 HALTED SHALL be cleared only by RST.
REQ-020 An 8-bit wait counter SHALL clear on entry to FETCH or MEM and increment each cycle the request is asserted without an ack.
REQ-021 When the wait counter is 255 and the ack is still low, the FSM SHALL go to TRAP with cause 1 (from FETCH) or cause 2 (from MEM).
REQ-022 An ack arriving in the same cycle the counter reaches 255 SHALL win over the timeout.
REQ-023 TRAP_CAUSE SHALL hold its value until the next trap or reset.
REQ-024 INSTRET SHALL wrap from 0xFFFFFFFF to 0 without a flag.
REQ-025 Outputs not listed for a state SHALL be 0 in that state.
REQ-026 All outputs SHALL be registered or decoded only from registered state; there SHALL be no combinational path from any input to IMEM_REQ or DMEM_REQ.

Reset
REQ-027 On RST=1 at a clock edge, the block SHALL set STATE=IDLE and all strobes to 0, including IMEM_REQ and DMEM_REQ.
REQ-028 On RST=1 at a clock edge, the block SHALL also clear TRAP_CAUSE, HALTED, INSTRET, the wait counter and all latched flags to 0.
REQ-029 Reset asserted in any state, including mid-access, SHALL drop requests at the next edge; a late ack after reset SHALL be ignored while in IDLE.

Verification
REQ-030 ALU op: RUN=1, IMEM_ACK on the 3rd FETCH cycle, all flags 0 -> states 0,1,1,1,2,3,5,1; REG_WE=1 and PC_SEL=0 in WB; INSTRET=1.
REQ-031 Store: IS_STORE=1, DMEM_ACK on the 4th MEM cycle -> DMEM_REQ=DMEM_WE=1 for 4 cycles; in WB REG_WE=0 and PC_SEL=0.
REQ-032 Branch: IS_BRANCH=1 and BR_TAKEN=1 -> WB has PC_SEL=1, REG_WE=0; with BR_TAKEN=0 -> PC_SEL=0.
REQ-033 Illegal: ILLEGAL=1 -> TRAP pulse for 1 cycle, TRAP_CAUSE=0, PC_SEL=2, HALTED=1; RUN held at 1 afterwards -> FSM stays in IDLE.
REQ-034 Timeout: IMEM_ACK held at 0 -> after 256 IMEM_REQ cycles, TRAP with TRAP_CAUSE=1; rerun with IMEM_ACK on the 256th cycle -> DECODE and no trap.
REQ-035 Reset mid-MEM with INSTRET=5 -> next cycle STATE=0, DMEM_REQ=0, INSTRET=0; INSTRET preloaded to 0xFFFFFFFF by forced retires -> wraps to 0.
